// File: rtl/tlc_pkg.sv
// -----------------------------------------------------------------------------
// tlc_pkg
// Shared definitions for the multi-phase traffic-light controller:
//   - lamp encodings per approach, {R,Y,G}
//   - ctrl_state encoding
//   - pack_lights(): expands (phase index, state, flash phase) into the
//     per-approach lamp vector, sized for the largest supported controller
//     (8 phases); callers truncate to 3*N_PHASES bits.
// -----------------------------------------------------------------------------
package tlc_pkg;

  localparam int MAX_PHASES = 8;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;

  localparam logic [1:0] ST_GREEN   = 2'd0;
  localparam logic [1:0] ST_YELLOW  = 2'd1;
  localparam logic [1:0] ST_ALL_RED = 2'd2;
  localparam logic [1:0] ST_FLASH   = 2'd3;

  function automatic logic [3*MAX_PHASES-1:0] pack_lights(
    input int         n_phases,
    input logic [2:0] idx,
    input logic [1:0] st,
    input logic       flash_on
  );
    logic [3*MAX_PHASES-1:0] v;
    v = '0;
    for (int p = 0; p < MAX_PHASES; p++) begin
      if (p < n_phases) begin
        case (st)
          ST_GREEN:   v[3*p +: 3] = (p == int'(idx)) ? LIGHT_GREEN  : LIGHT_RED;
          ST_YELLOW:  v[3*p +: 3] = (p == int'(idx)) ? LIGHT_YELLOW : LIGHT_RED;
          ST_ALL_RED: v[3*p +: 3] = LIGHT_RED;
          default: begin
            // Flash: main road blinks yellow, side roads blink red.
            if (p == 0) v[3*p +: 3] = flash_on ? LIGHT_YELLOW : LIGHT_OFF;
            else        v[3*p +: 3] = flash_on ? LIGHT_RED    : LIGHT_OFF;
          end
        endcase
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/tlc_next_phase.sv
// -----------------------------------------------------------------------------
// tlc_next_phase
// Combinational round-robin selector for the next green phase.
// Ports:
//   demand   in  N_PHASES  latched demand per phase (bit 0 never selects)
//   cur_idx  in  IDX_W     phase that was last green
//   next_idx out IDX_W     lowest pending phase above cur_idx, else phase 0
// Wrapping back to phase 0 (instead of to the lowest pending side phase) is
// what makes the main road intervene between consecutive round-robin sweeps.
// -----------------------------------------------------------------------------
module tlc_next_phase
  import tlc_pkg::*;
#(
  parameter int N_PHASES = 4,
  parameter int IDX_W    = $clog2(N_PHASES)
) (
  input  logic [N_PHASES-1:0] demand,
  input  logic [IDX_W-1:0]    cur_idx,
  output logic [IDX_W-1:0]    next_idx
);

  logic [N_PHASES-1:0] above;

  // Candidates: pending phases strictly above the current one. Bit 0 can
  // never qualify since 0 > cur_idx is always false.
  genvar gi;
  generate
    for (gi = 0; gi < N_PHASES; gi++) begin : g_above
      assign above[gi] = demand[gi] && (IDX_W'(gi) > cur_idx);
    end
  endgenerate

  // Descending scan: the last hit written is the lowest candidate.
  always_comb begin
    next_idx = '0;
    for (int i = N_PHASES - 1; i >= 0; i--) begin
      if (above[i]) next_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/tlc_multi_phase.sv
// -----------------------------------------------------------------------------
// tlc_multi_phase
// N-approach traffic-light controller. Phase 0 (main road) rests in green;
// side phases are served on latched sensor demand in round-robin order with
// min/max green, yellow and all-red clearance counted in prescaler ticks.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   tick         in   one-cycle timing strobe; tick=0 freezes state and timer
//   sensor       in   N_PHASES vehicle-present levels (bit 0 ignored)
//   flash_req    in   flash-mode request (only with TLC_FLASH_EN)
//   lights       out  3*N_PHASES lamps, phase i at [3i+2:3i], {R,Y,G}
//   active_phase out  phase in GREEN/YELLOW
//   ctrl_state   out  0 GREEN, 1 YELLOW, 2 ALL_RED, 3 FLASH
// Build option: define TLC_FLASH_EN to add flash_req and the FLASH state.
// -----------------------------------------------------------------------------
module tlc_multi_phase
  import tlc_pkg::*;
#(
  parameter int N_PHASES  = 4,
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 10,
  parameter int MAX_GREEN = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [N_PHASES-1:0]           sensor,
`ifdef TLC_FLASH_EN
  input  logic                          flash_req,
`endif
  output logic [3*N_PHASES-1:0]         lights,
  output logic [$clog2(N_PHASES)-1:0]   active_phase,
  output logic [1:0]                    ctrl_state
);

  localparam int IDX_W = $clog2(N_PHASES);
  localparam int LW    = 3 * N_PHASES;

  localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_M1  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] T_SAT  = '1;

  localparam logic [LW-1:0] LIGHTS_RST = LW'(pack_lights(N_PHASES, 3'd0, ST_GREEN, 1'b0));

  generate
    if (N_PHASES < 2 || N_PHASES > MAX_PHASES) begin : g_bad_phases
      $error("tlc_multi_phase: N_PHASES must be 2..8");
    end
    if (MIN_GREEN < 1 || MIN_GREEN > MAX_GREEN || MAX_GREEN >= (2 ** CNT_W)) begin : g_bad_green
      $error("tlc_multi_phase: need 1 <= MIN_GREEN <= MAX_GREEN < 2**CNT_W");
    end
    if (YELLOW_T < 1 || ALLRED_T < 1) begin : g_bad_clear
      $error("tlc_multi_phase: YELLOW_T and ALLRED_T must be >= 1");
    end
  endgenerate

  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    active_q, active_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [N_PHASES-1:0] demand_q, demand_d;
  logic [LW-1:0]       lights_q, lights_d;
  logic                flash_on_q, flash_on_d;
  logic                from_flash_q, from_flash_d;

  logic [IDX_W-1:0]    next_idx;
  logic                green_done;
  logic                flash_req_i;

`ifdef TLC_FLASH_EN
  assign flash_req_i = flash_req;
`else
  assign flash_req_i = 1'b0;
`endif

  tlc_next_phase #(
    .N_PHASES (N_PHASES),
    .IDX_W    (IDX_W)
  ) u_next_phase (
    .demand   (demand_q),
    .cur_idx  (active_q),
    .next_idx (next_idx)
  );

  // Green termination: main road leaves once min green is served and someone
  // is waiting; side roads gap out when their sensor clears or max out.
  always_comb begin
    green_done = 1'b0;
    if (active_q == '0) begin
      green_done = (timer_q >= MIN_M1) && ((demand_q != '0) || flash_req_i);
    end else begin
      green_done = ((timer_q >= MIN_M1) && !sensor[active_q]) || (timer_q == MAX_M1);
    end
  end

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    timer_d      = timer_q;
    demand_d     = demand_q;
    flash_on_d   = flash_on_q;
    from_flash_d = from_flash_q;

    // Demand latches on every clock, independent of tick, except for the
    // phase currently holding green.
    for (int i = 1; i < N_PHASES; i++) begin
      if (sensor[i] && !((state_q == ST_GREEN) && (active_q == IDX_W'(i)))) begin
        demand_d[i] = 1'b1;
      end
    end
    demand_d[0] = 1'b0;

    if (tick) begin
      case (state_q)
        ST_GREEN: begin
          if (green_done) state_d = ST_YELLOW;
        end
        ST_YELLOW: begin
          if (timer_q == YEL_M1) state_d = ST_ALL_RED;
        end
        ST_ALL_RED: begin
          if (timer_q == AR_M1) begin
            from_flash_d = 1'b0;
            if (flash_req_i) begin
              state_d    = ST_FLASH;
              active_d   = '0;
              flash_on_d = 1'b1;
            end else begin
              // Selection happens here so demand seen during clearance counts;
              // leaving flash always lands on the main road.
              state_d            = ST_GREEN;
              active_d           = from_flash_q ? '0 : next_idx;
              demand_d[active_d] = 1'b0;
            end
          end
        end
`ifdef TLC_FLASH_EN
        ST_FLASH: begin
          if (!flash_req_i) begin
            state_d      = ST_ALL_RED;
            from_flash_d = 1'b1;
          end else begin
            flash_on_d = ~flash_on_q;
          end
        end
`endif
        default: state_d = ST_GREEN;
      endcase

      // Timer restarts on every state change and saturates while resting so
      // a long main-road green never wraps below MIN_GREEN.
      if (state_d != state_q) timer_d = '0;
      else if (timer_q != T_SAT) timer_d = timer_q + 1'b1;
    end

    lights_d = LW'(pack_lights(N_PHASES, 3'(active_d), state_d, flash_on_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_GREEN;
      active_q     <= '0;
      timer_q      <= '0;
      demand_q     <= '0;
      lights_q     <= LIGHTS_RST;
      flash_on_q   <= 1'b0;
      from_flash_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      timer_q      <= timer_d;
      demand_q     <= demand_d;
      lights_q     <= lights_d;
      flash_on_q   <= flash_on_d;
      from_flash_q <= from_flash_d;
    end
  end

  assign lights       = lights_q;
  assign active_phase = active_q;
  assign ctrl_state   = state_q;

endmodule

// File: doc/tlc_multi_phase.md
Name: tlc_multi_phase

Overview:
Parametrised successor to the two-road highway/farm traffic-light controller. Drives N_PHASES approaches. Phase 0 is the main road and rests in green. Side phases 1..N_PHASES-1 are served on sensor demand in round-robin order, with min/max green, yellow and all-red clearance timed in prescaled ticks. Sits between the sensor-conditioning logic and the lamp drivers.

Parameters:
N_PHASES, 4, number of approaches (2..8); phase 0 is the main road
CNT_W, 8, width of the tick timer
MIN_GREEN, 10, minimum green length in ticks, all phases
MAX_GREEN, 30, maximum green length in ticks, side phases only
YELLOW_T, 3, yellow length in ticks
ALLRED_T, 1, all-red clearance in ticks (must be >= 1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick  in  1  one-cycle timing strobe from the prescaler
sensor  in  N_PHASES  vehicle-present level per phase; bit 0 is ignored
flash_req  in  1  flash-mode request; present only with TLC_FLASH_EN
lights  out  3*N_PHASES  per phase {R,Y,G}: 3'b100 red, 3'b010 yellow, 3'b001 green; phase i occupies bits [3i+2:3i]
active_phase  out  $clog2(N_PHASES)  index of the phase currently in GREEN/YELLOW
ctrl_state  out  2  0 GREEN, 1 YELLOW, 2 ALL_RED, 3 FLASH

Behaviour:
- Design has one clock and one reset: clk, with rst asynchronous and active-high. rst has immediate effect, including mid-operation.
- Reset values:
  - State GREEN, active_phase 0, timer 0, demand 0.
  - lights: phase 0 = 001, all other phases = 100.
- All outputs are registered and update on the same edge as the state register.
- Timer:
  - Advances only on cycles where tick=1.
  - Clears on every state change.
  - tick=0 freezes state and timer.
- Demand latch, for i >= 1:
  - demand[i] is set on any clk edge where sensor[i]=1, independent of tick.
  - It is not set while phase i itself is GREEN.
  - It is cleared on entry to GREEN of phase i.
- GREEN, phase 0:
  - Held indefinitely while demand == 0.
  - Moves to YELLOW on a tick where timer == MIN_GREEN-1 or later and demand != 0.
- GREEN, side phase i, moves to YELLOW on a tick where either:
  - timer >= MIN_GREEN-1 and sensor[i]=0 (gap-out), or
  - timer == MAX_GREEN-1 (max-out).
- YELLOW: the active phase shows 010; moves to ALL_RED on the tick where timer == YELLOW_T-1.
- ALL_RED: every phase shows 100; moves to GREEN on the tick where timer == ALLRED_T-1.
- Next-phase selection happens at ALL_RED exit, so demand latched during yellow and all-red counts:
  - Take the lowest-index pending phase with index > current.
  - Otherwise, from phase 0, take the lowest pending phase.
  - Otherwise return to phase 0.
  - A side phase never follows itself directly; phase 0 always intervenes.
- Invariant: at most one phase non-red in every cycle. A phase never goes from green to red without YELLOW_T yellow ticks followed by ALLRED_T all-red ticks.
- Simultaneous sensor on several phases: all are latched and served in ascending index order.
- Elaboration-time checks: 1 <= MIN_GREEN <= MAX_GREEN < 2**CNT_W; YELLOW_T >= 1; ALLRED_T >= 1.

Optional Feature:
TLC_FLASH_EN
- Defined: flash_req port exists.
- On flash_req=1, the current green completes normally (honouring MIN_GREEN, then YELLOW and ALL_RED). Instead of the next GREEN, the controller enters FLASH.
- In FLASH, lights toggle every tick:
  - phase 0 alternates 010 / 000.
  - others alternate 100 / 000.
- When flash_req drops, the controller leaves FLASH via ALL_RED into GREEN of phase 0.
- Demand keeps latching throughout.
- Undefined: no port, no FLASH state; ctrl_state never reaches 3.

Decomposition:
- Package tlc_pkg holds:
  - light encodings LIGHT_RED / LIGHT_YELLOW / LIGHT_GREEN / LIGHT_OFF.
  - ctrl_state encoding.
  - a function packing a phase index plus state into the lights vector.
- One sub-module, tlc_next_phase: combinational round-robin selector; inputs demand vector and current index, outputs next index.

Test Plan:
Common setup: N_PHASES=4, MIN_GREEN=4, MAX_GREEN=8, YELLOW_T=2, ALLRED_T=1, tick tied high.
1. Reset, no sensor for 50 cycles -> lights stays 12'b100_100_100_001, ctrl_state 0 throughout.
2. One-cycle sensor[2] pulse at cycle 20 -> phase 0 yellow for 2 cycles, all-red for 1, phase 2 green for exactly 4 (gap-out), then yellow 2, all-red 1, phase 0 green again.
3. sensor[1] held high -> phase 1 green exactly 8 cycles (max-out). Demand re-latches, so phase 0 green exactly 4 cycles, then phase 1 green again.
4. sensor[1] and sensor[3] pulsed on the same cycle -> service order 1, 3, 0. Never two non-red phases in any cycle (checked by assertion).
5. rst asserted mid-YELLOW of phase 2 -> lights = 12'b100_100_100_001 in the same cycle, demand cleared.
6. (TLC_FLASH_EN) flash_req high during phase 0 green -> after MIN_GREEN, YELLOW and ALL_RED, phase 0 alternates 010/000 and others 100/000 every cycle. flash_req low -> 1 all-red cycle, then phase 0 green.
